// File: rtl/ofm_pingpong_ctrl_pkg.sv
// Shared OFM buffer definitions: bank state encoding and output-frame geometry.
// Imported by the ping-pong controller and by anything that sizes a BUFFER bank.
package cnn_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    function automatic int ofm_depth(input int ifm, input int k, input int s, input int p);
        return (ifm - k + 2 * p) / s + 1;
    endfunction

    function automatic int ofm_frame(input int ifm, input int k, input int s, input int p);
        return ofm_depth(ifm, k, s, p) * ofm_depth(ifm, k, s, p);
    endfunction

    // Keeps a one-pixel frame from collapsing the counter to zero bits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int OFM_DEPTH = ofm_depth(9, 4, 2, 2);
    localparam int OFM_FRAME = ofm_frame(9, 4, 2, 2);

endpackage

// File: rtl/ofm_pingpong_ctrl_if.sv
// Producer/consumer and BUFFER-bank signals of the OFM ping-pong controller.
// The controller connects through the slave modport; its environment uses master.
interface ofm_pingpong_ctrl_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic                  rd_req;
    logic                  frame_ready;
    logic                  we0;
    logic                  we1;
    logic                  re0;
    logic                  re1;
    logic [DATA_WIDTH-1:0] buf0_dout;
    logic [DATA_WIDTH-1:0] buf1_dout;
    logic [DATA_WIDTH-1:0] d_out;
    logic                  d_valid;
    logic                  frame_done;
    logic                  err_ovf;
    logic [7:0]            drop_cnt;

    modport master (
        output wr_valid, rd_req, buf0_dout, buf1_dout,
        input  wr_ready, frame_ready, we0, we1, re0, re1,
               d_out, d_valid, frame_done, err_ovf, drop_cnt
    );

    modport slave (
        input  wr_valid, rd_req, buf0_dout, buf1_dout,
        output wr_ready, frame_ready, we0, we1, re0, re1,
               d_out, d_valid, frame_done, err_ovf, drop_cnt
    );

endinterface

// File: rtl/ofm_pingpong_ctrl_bank_fsm.sv
// Per-bank lifecycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
// Hits are pre-qualified by the top; *_last marks the FRAME-th word of a fill or drain.
module ofm_bank_fsm
    import cnn_buf_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_hit,
    input  logic        rd_hit,
    input  logic        wr_last,
    input  logic        rd_last,
    output bank_state_t state
);

    bank_state_t state_q;
    bank_state_t state_d;

    // NOTE: reset is synchronous, so rst_n is sampled only inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // NOTE: state_d is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:    if (wr_hit) state_d = wr_last ? FULL : FILLING;
            FILLING:  if (wr_hit && wr_last) state_d = FULL;
            FULL:     if (rd_hit) state_d = rd_last ? EMPTY : DRAINING;
            DRAINING: if (rd_hit && rd_last) state_d = EMPTY;
        endcase
    end

    always_comb state = state_q;

endmodule

// File: rtl/ofm_pingpong_ctrl.sv
// Ping-pong sequencer for two OFM BUFFER banks between a conv PE and the next layer.
// Build option: define OFM_PPCTRL_ERR_STATUS_EN to enable the err_ovf / drop_cnt logic.
module ofm_pingpong_ctrl
    import cnn_buf_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int IFM_SIZE    = 9,
    parameter int KERNEL_SIZE = 4,
    parameter int STRIDE      = 2,
    parameter int PAD         = 2
) (
    input logic                clk,
    input logic                rst_n,
    ofm_pingpong_ctrl_if.slave bus
);

    localparam int            FRAME = ofm_frame(IFM_SIZE, KERNEL_SIZE, STRIDE, PAD);
    localparam int            CW    = cnt_width(FRAME);
    localparam logic [CW-1:0] LAST  = CW'(FRAME - 1);

    logic                  wr_bank;
    logic                  rd_bank;
    logic [CW-1:0]         wr_cnt;
    logic [CW-1:0]         rd_cnt;
    bank_state_t           bank_st [2];
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  we;
    logic                  re;
    logic                  wr_last;
    logic                  rd_last;
    logic [1:0]            wr_hit;
    logic [1:0]            rd_hit;
    logic                  rd_sel_q;
    logic                  d_valid_q;
    logic                  frame_done_q;
    logic [DATA_WIDTH-1:0] rd_mux;

    // Enables are gated by rst_n so nothing reaches the banks while reset is held.
    always_comb begin
        wr_ok   = rst_n && (bank_st[wr_bank] inside {EMPTY, FILLING});
        rd_ok   = rst_n && (bank_st[rd_bank] inside {FULL, DRAINING});
        we      = bus.wr_valid && wr_ok;
        re      = bus.rd_req && rd_ok;
        wr_last = (wr_cnt == LAST);
        rd_last = (rd_cnt == LAST);
        wr_hit  = '0;
        rd_hit  = '0;
        wr_hit[wr_bank] = we;
        rd_hit[rd_bank] = re;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        ofm_bank_fsm u_fsm (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr_hit (wr_hit[b]),
            .rd_hit (rd_hit[b]),
            .wr_last(wr_last),
            .rd_last(rd_last),
            .state  (bank_st[b])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            rd_sel_q     <= 1'b0;
            d_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            if (we) begin
                wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
                if (wr_last) wr_bank <= ~wr_bank;
            end
            if (re) begin
                rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
                if (rd_last) rd_bank <= ~rd_bank;
            end
            // BUFFER data appears one cycle after re, so the bank select is delayed to match.
            rd_sel_q     <= rd_bank;
            d_valid_q    <= re;
            frame_done_q <= re && rd_last;
        end
    end

    always_comb rd_mux = d_valid_q ? (rd_sel_q ? bus.buf1_dout : bus.buf0_dout) : '0;

    assign bus.wr_ready    = wr_ok;
    assign bus.frame_ready = rst_n && ((bank_st[0] inside {FULL, DRAINING}) ||
                                       (bank_st[1] inside {FULL, DRAINING}));
    assign bus.we0         = wr_hit[0];
    assign bus.we1         = wr_hit[1];
    assign bus.re0         = rd_hit[0];
    assign bus.re1         = rd_hit[1];
    assign bus.d_out       = rd_mux;
    assign bus.d_valid     = d_valid_q;
    assign bus.frame_done  = frame_done_q;

`ifdef OFM_PPCTRL_ERR_STATUS_EN
    logic       drop;
    logic       err_q;
    logic [7:0] drop_q;

    assign drop = bus.wr_valid && !wr_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            drop_q <= '0;
        end else if (drop) begin
            err_q <= 1'b1;
            if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    assign bus.err_ovf  = err_q;
    assign bus.drop_cnt = drop_q;
`else
    assign bus.err_ovf  = 1'b0;
    assign bus.drop_cnt = '0;
`endif

endmodule

// File: tb/tb_ofm_pingpong_ctrl.sv
// Self-checking bench for ofm_pingpong_ctrl: two behavioural BUFFER banks plus a frame-level
// reference model (fill/drain word counts per bank, frame counters pick the banks).
module tb_ofm_pingpong_ctrl;

    localparam int DW    = 16;
    localparam int FRAME = 25;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ofm_pingpong_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    ofm_pingpong_ctrl #(
        .DATA_WIDTH (DW),
        .IFM_SIZE   (9),
        .KERNEL_SIZE(4),
        .STRIDE     (2),
        .PAD        (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural BUFFER banks: pointers wrap at FRAME, 1-cycle read latency, same reset net.
    logic [DW-1:0] wr_data;
    logic [DW-1:0] env_mem [2][FRAME];
    int            env_wp  [2];
    int            env_rp  [2];

    always @(posedge clk) begin
        if (!rst_n) begin
            env_wp[0] <= 0; env_wp[1] <= 0;
            env_rp[0] <= 0; env_rp[1] <= 0;
            bus.buf0_dout <= '0;
            bus.buf1_dout <= '0;
        end else begin
            if (bus.we0) begin
                env_mem[0][env_wp[0]] <= wr_data;
                env_wp[0] <= (env_wp[0] + 1) % FRAME;
            end
            if (bus.we1) begin
                env_mem[1][env_wp[1]] <= wr_data;
                env_wp[1] <= (env_wp[1] + 1) % FRAME;
            end
            if (bus.re0) begin
                bus.buf0_dout <= env_mem[0][env_rp[0]];
                env_rp[0] <= (env_rp[0] + 1) % FRAME;
            end
            if (bus.re1) begin
                bus.buf1_dout <= env_mem[1][env_rp[1]];
                env_rp[1] <= (env_rp[1] + 1) % FRAME;
            end
        end
    end

    // Reference model: words written/read per bank; frames written/read select the banks.
    int            m_in  [2];
    int            m_out [2];
    int            m_fw, m_fr, m_drops;
    bit            m_err;
    logic [DW-1:0] m_mem [2][FRAME];
    logic          m_dv, m_fd;
    logic [DW-1:0] m_dout;

    // Snapshot of DUT outputs from the most recent cycle (sampled mid-low-phase).
    logic          s_we0, s_we1, s_re0, s_re1, s_wr_ready, s_frame_ready, s_dv, s_fd, s_err;
    logic [DW-1:0] s_dout;
    logic [7:0]    s_drop;

    task automatic model_reset();
        m_in[0] = 0; m_in[1] = 0; m_out[0] = 0; m_out[1] = 0;
        m_fw = 0; m_fr = 0; m_drops = 0; m_err = 0;
        m_dv = 0; m_fd = 0; m_dout = '0;
    endtask

    task automatic run_cycle(input logic wv, input logic rq, input logic rstn);
        int         wb, rb;
        logic       e_wrdy, e_we, e_re, e_fr, e_err;
        logic [7:0] e_drop;
        logic [5:0] e_comb, o_comb;
        @(negedge clk);
        rst_n        = rstn;
        bus.wr_valid = wv;
        bus.rd_req   = rq;
        wr_data      = DW'($urandom);
        #1;
        wb     = m_fw % 2;
        rb     = m_fr % 2;
        e_wrdy = rstn && (m_in[wb] < FRAME);
        e_we   = wv && e_wrdy;
        e_re   = rstn && rq && (m_in[rb] == FRAME);
        e_fr   = rstn && (m_in[0] == FRAME || m_in[1] == FRAME);
        e_comb = {e_we && wb == 0, e_we && wb == 1, e_re && rb == 0, e_re && rb == 1, e_wrdy, e_fr};
`ifdef OFM_PPCTRL_ERR_STATUS_EN
        e_err  = m_err;
        e_drop = 8'(m_drops);
`else
        e_err  = 1'b0;
        e_drop = 8'd0;
`endif
        o_comb = {bus.we0, bus.we1, bus.re0, bus.re1, bus.wr_ready, bus.frame_ready};
        {s_we0, s_we1, s_re0, s_re1, s_wr_ready, s_frame_ready} = o_comb;
        s_dv = bus.d_valid; s_fd = bus.frame_done; s_dout = bus.d_out;
        s_err = bus.err_ovf; s_drop = bus.drop_cnt;

        checks++;
        if (o_comb !== e_comb) begin
            failures++;
            $display("FAIL enables t=%0t {we0,we1,re0,re1,wr_ready,frame_ready} got %b expected %b",
                     $time, o_comb, e_comb);
        end
        checks++;
        if ({bus.d_valid, bus.frame_done} !== {m_dv, m_fd}) begin
            failures++;
            $display("FAIL read_strobes t=%0t {d_valid,frame_done} got %b expected %b",
                     $time, {bus.d_valid, bus.frame_done}, {m_dv, m_fd});
        end
        if (m_dv) begin
            checks++;
            if (bus.d_out !== m_dout) begin
                failures++;
                $display("FAIL d_out t=%0t got %h expected %h", $time, bus.d_out, m_dout);
            end
        end
        checks++;
        if ({bus.err_ovf, bus.drop_cnt} !== {e_err, e_drop}) begin
            failures++;
            $display("FAIL err_status t=%0t err_ovf/drop_cnt got %b/%0d expected %b/%0d",
                     $time, bus.err_ovf, bus.drop_cnt, e_err, e_drop);
        end

        @(posedge clk);
        if (!rstn) begin
            model_reset();
        end else begin
            m_dv = e_re;
            m_fd = 1'b0;
            if (e_re) begin
                m_dout = m_mem[rb][m_out[rb]];
                m_out[rb]++;
                if (m_out[rb] == FRAME) begin
                    m_fd = 1'b1; m_in[rb] = 0; m_out[rb] = 0; m_fr++;
                end
            end
            if (e_we) begin
                m_mem[wb][m_in[wb]] = wr_data;
                m_in[wb]++;
                if (m_in[wb] == FRAME) m_fw++;
            end
            if (wv && !e_wrdy) begin
                m_err = 1'b1;
                if (m_drops < 255) m_drops++;
            end
        end
    endtask

    task automatic test_reset();
        run_cycle(1'b0, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b1, 1'b0);
        checks++;
        if ({s_we0, s_we1, s_re0, s_re1, s_wr_ready, s_frame_ready, s_dv, s_fd} !== 8'b0) begin
            failures++;
            $display("FAIL reset_outputs got %b expected 00000000",
                     {s_we0, s_we1, s_re0, s_re1, s_wr_ready, s_frame_ready, s_dv, s_fd});
        end
        run_cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (s_dout !== '0 || s_wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset d_out/wr_ready got %h/%b expected 0000/1", s_dout, s_wr_ready);
        end
    endtask

    task automatic test_fill();
        int n_we0 = 0, n_we1 = 0, first_fr = 0;
        for (int i = 1; i <= 50; i++) begin
            run_cycle(1'b1, 1'b0, 1'b1);
            n_we0 += int'(s_we0);
            n_we1 += int'(s_we1);
            if (s_we1 && i <= 25) begin
                failures++; checks++;
                $display("FAIL fill_order we1 at cycle %0d expected bank0 first", i);
            end
            if (s_frame_ready && first_fr == 0) first_fr = i;
        end
        run_cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (n_we0 != 25 || n_we1 != 25) begin
            failures++;
            $display("FAIL fill_counts we0/we1 got %0d/%0d expected 25/25", n_we0, n_we1);
        end
        checks++;
        if (first_fr != 26) begin
            failures++;
            $display("FAIL fill_frame_ready first cycle got %0d expected 26", first_fr);
        end
        checks++;
        if (s_wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_wr_ready cycle 51 got %b expected 0", s_wr_ready);
        end
    endtask

    task automatic test_overflow();
        int n_we = 0;
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b1, 1'b0, 1'b1);
            n_we += int'(s_we0) + int'(s_we1);
        end
        run_cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (n_we != 0) begin
            failures++;
            $display("FAIL overflow_we got %0d writes expected 0", n_we);
        end
        checks++;
`ifdef OFM_PPCTRL_ERR_STATUS_EN
        if (s_err !== 1'b1 || s_drop !== 8'd3) begin
            failures++;
            $display("FAIL overflow_status err/drop got %b/%0d expected 1/3", s_err, s_drop);
        end
`else
        if (s_err !== 1'b0 || s_drop !== 8'd0) begin
            failures++;
            $display("FAIL overflow_status err/drop got %b/%0d expected 0/0", s_err, s_drop);
        end
`endif
    endtask

    task automatic test_drain();
        int n_re0 = 0, n_re1 = 0, n_dv = 0, fd_at = 0, n_fd = 0;
        logic rdy25 = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            run_cycle(1'b0, (i <= 25), 1'b1);
            n_re0 += int'(s_re0);
            n_re1 += int'(s_re1);
            n_dv  += int'(s_dv);
            if (s_fd) begin n_fd++; fd_at = i; end
            if (i == 25) rdy25 = s_wr_ready;
        end
        checks++;
        if (n_re0 != 25 || n_re1 != 0 || n_dv != 25) begin
            failures++;
            $display("FAIL drain_counts re0/re1/d_valid got %0d/%0d/%0d expected 25/0/25",
                     n_re0, n_re1, n_dv);
        end
        checks++;
        if (n_fd != 1 || fd_at != 26) begin
            failures++;
            $display("FAIL drain_frame_done pulses/cycle got %0d/%0d expected 1/26", n_fd, fd_at);
        end
        checks++;
        if (rdy25 !== 1'b0 || s_wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL drain_wr_ready cycle25/26 got %b/%b expected 0/1", rdy25, s_wr_ready);
        end
    endtask

    task automatic test_back_to_back();
        int n_fd = 0, gaps = 0;
        for (int i = 1; i <= 100; i++) begin
            run_cycle(1'b1, 1'b1, 1'b1);
            n_fd += int'(s_fd);
            if (i >= 2 && !s_dv) gaps++;
        end
        checks++;
        if (n_fd != 3) begin
            failures++;
            $display("FAIL stream_frame_done got %0d pulses expected 3", n_fd);
        end
        checks++;
        if (gaps != 0) begin
            failures++;
            $display("FAIL stream_d_valid got %0d gap cycles expected 0", gaps);
        end
        checks++;
`ifdef OFM_PPCTRL_ERR_STATUS_EN
        if (s_drop !== 8'd3) begin
`else
        if (s_drop !== 8'd0) begin
`endif
            failures++;
            $display("FAIL stream_drops drop_cnt got %0d, no new drops expected", s_drop);
        end
        run_cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midfill();
        logic fr_at25;
        run_cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) run_cycle(1'b1, 1'b0, 1'b1);
        run_cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (s_we0 !== 1'b0 || s_wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL midfill_in_reset we0/wr_ready got %b/%b expected 0/0", s_we0, s_wr_ready);
        end
        for (int i = 1; i <= 25; i++) begin
            run_cycle(1'b1, 1'b0, 1'b1);
            if (i == 25) fr_at25 = s_frame_ready;
        end
        run_cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (fr_at25 !== 1'b0 || s_frame_ready !== 1'b1) begin
            failures++;
            $display("FAIL midfill_frame_ready write25/next got %b/%b expected 0/1",
                     fr_at25, s_frame_ready);
        end
    endtask

    task automatic test_rd_toggle();
        int n_re = 0, n_fd = 0, wrong = 0;
        logic rq;
        for (int i = 0; i < 52; i++) begin
            rq = (i % 2 == 0);
            run_cycle(1'b0, rq, 1'b1);
            n_re += int'(s_re0) + int'(s_re1);
            n_fd += int'(s_fd);
            if (i <= 48 && s_re0 !== rq) wrong++;
            if (i == 50 && (s_re0 || s_re1)) wrong++;
        end
        checks++;
        if (n_re != 25 || wrong != 0) begin
            failures++;
            $display("FAIL toggle_re total/mismatched got %0d/%0d expected 25/0", n_re, wrong);
        end
        checks++;
        if (n_fd != 1) begin
            failures++;
            $display("FAIL toggle_frame_done got %0d pulses expected 1", n_fd);
        end
    endtask

    task automatic test_random();
        int n_fd = 0;
        for (int i = 0; i < 600; i++) begin
            run_cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                      ($urandom_range(0, 199) != 0));
            n_fd += int'(s_fd);
        end
        checks++;
        if (n_fd == 0) begin
            failures++;
            $display("FAIL random_progress frame_done pulses got 0 over 600 cycles expected >0");
        end
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.rd_req   = 1'b0;
        wr_data      = '0;
        model_reset();
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_back_to_back();
        test_reset_midfill();
        test_rd_toggle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
